// File: rtl/mem_bist_ctrl.sv
// March-free write/read-back BIST controller for a single-port memory.
// Optional inverted second pass when MEM_BIST_INVERT_PASS_EN is defined.
module mem_bist_ctrl #(
  parameter int unsigned       ADDR_W = 4,
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       DEPTH  = 16,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(8'hA5)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [7:0]        fail_cnt
);

  localparam int unsigned       CNT_W = 8;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

`ifdef MEM_BIST_INVERT_PASS_EN
  typedef enum logic [2:0] {IDLE, WR, RD, WR_INV, RD_INV, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;
`endif

  state_t            state;
  logic [DATA_W-1:0] expected;
  logic              mismatch;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [ADDR_W-1:0] faddr_nxt;
  logic              pass_nxt;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    return SEED ^ DATA_W'(a);
  endfunction

  // Read-back comparison and result bookkeeping for the current read address
  always_comb begin
    expected = pattern(mem_addr);
`ifdef MEM_BIST_INVERT_PASS_EN
    if (state == RD_INV) expected = ~pattern(mem_addr);
`endif
    mismatch  = !mem_valid || (mem_rdata != expected);
    cnt_nxt   = fail_cnt;
    faddr_nxt = fail_addr;
    if (mismatch) begin
      if (fail_cnt != {CNT_W{1'b1}}) cnt_nxt = fail_cnt + CNT_W'(1);
      if (fail_cnt == '0)            faddr_nxt = mem_addr;
    end
    pass_nxt = (cnt_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_rw    <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          mem_rw   <= 1'b1;
          mem_addr <= '0;
          done     <= 1'b0;
          if (start) begin
            state     <= WR;
            mem_rw    <= 1'b0;
            mem_wdata <= pattern('0);
            busy      <= 1'b1;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_cnt  <= '0;
          end
        end
        WR: begin
          if (mem_addr == LAST) begin
            state    <= RD;
            mem_rw   <= 1'b1;
            mem_addr <= '0;
          end else begin
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_wdata <= pattern(mem_addr + ADDR_W'(1));
          end
        end
        RD: begin
          fail_cnt  <= cnt_nxt;
          fail_addr <= faddr_nxt;
          if (mem_addr == LAST) begin
            mem_addr <= '0;
`ifdef MEM_BIST_INVERT_PASS_EN
            state     <= WR_INV;
            mem_rw    <= 1'b0;
            mem_wdata <= ~pattern('0);
`else
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= pass_nxt;
`endif
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
          end
        end
`ifdef MEM_BIST_INVERT_PASS_EN
        WR_INV: begin
          if (mem_addr == LAST) begin
            state    <= RD_INV;
            mem_rw   <= 1'b1;
            mem_addr <= '0;
          end else begin
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_wdata <= ~pattern(mem_addr + ADDR_W'(1));
          end
        end
        RD_INV: begin
          fail_cnt  <= cnt_nxt;
          fail_addr <= faddr_nxt;
          if (mem_addr == LAST) begin
            state    <= DONE;
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= pass_nxt;
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
          end
        end
`endif
        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          mem_rw   <= 1'b1;
          mem_addr <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: cycle-count reference model plus directed scenarios.
module tb_mem_bist_ctrl;
  localparam int unsigned D = 16;
`ifdef MEM_BIST_INVERT_PASS_EN
  localparam int NP = 2;
  localparam int EXP_DONE = 65;
`else
  localparam int NP = 1;
  localparam int EXP_DONE = 33;
`endif
  localparam int L = 2 * D * NP;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic       mem_rw, mem_valid, busy, done, pass;
  logic [3:0] mem_addr, fail_addr;
  logic [7:0] mem_wdata, mem_rdata, fail_cnt;

  mem_bist_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .busy(busy), .done(done), .pass(pass), .fail_addr(fail_addr), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // Memory with a stuck-at-zero fault option and a global valid kill
  logic [7:0] mem [D];
  bit fault_en = 0, invalid_all = 0;
  int fault_a = 5;
  always @(posedge clk) if (!mem_rw) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = (fault_en && int'(mem_addr) == fault_a) ? 8'h00 : mem[mem_addr];
  assign mem_valid = !invalid_all;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int a, input int p);
    logic [7:0] v;
    v = 8'hA5 ^ 8'(a);
    return (p != 0) ? ~v : v;
  endfunction

  // Reference model: run_k = cycles since the start edge, 0 when idle
  int  run_k = 0, m_cnt = 0, m_faddr = 0;
  bit  m_pass = 0, chk_en = 0;
  task automatic compute_results();
    bit bad;
    m_cnt = 0; m_faddr = 0;
    for (int p = 0; p < NP; p++)
      for (int a = 0; a < int'(D); a++) begin
        bad = invalid_all || (fault_en && a == fault_a && pat(a, p) != 8'h00);
        if (bad) begin
          if (m_cnt == 0) m_faddr = a;
          if (m_cnt < 255) m_cnt++;
        end
      end
    m_pass = (m_cnt == 0);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      run_k = 0; m_pass = 0; m_cnt = 0; m_faddr = 0; chk_en = 1;
    end else if (run_k == 0) begin
      if (start) begin run_k = 1; m_pass = 0; m_cnt = 0; m_faddr = 0; end
    end else if (run_k == L + 1) begin
      run_k = 0;
    end else begin
      run_k++;
      if (run_k == L + 1) compute_results();
    end
  end

  int ph, ad;
  always @(negedge clk) if (chk_en) begin
    if (run_k == 0 || run_k == L + 1) begin
      chk("busy", busy, 0);
      chk("done", done, 32'(run_k == L + 1));
      chk("mem_rw", mem_rw, 1);
      chk("mem_addr", mem_addr, 0);
      chk("pass", pass, m_pass);
      chk("fail_cnt", fail_cnt, m_cnt);
      chk("fail_addr", fail_addr, m_faddr);
    end else begin
      ph = (run_k - 1) / int'(D);
      ad = (run_k - 1) % int'(D);
      chk("busy", busy, 1);
      chk("done", done, 0);
      chk("mem_rw", mem_rw, ph % 2);
      chk("mem_addr", mem_addr, ad);
      chk("pass_run", pass, 0);
      if (ph % 2 == 0) chk("mem_wdata", mem_wdata, pat(ad, ph / 2));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One run: start sampled at edge 0; iteration c observes cycle c
  task automatic run(input int pulse_at, input int rst_at, output int done_cyc,
                     output int done_n, output int busy_n, output logic [7:0] wd3);
    done_cyc = 0; done_n = 0; busy_n = 0; wd3 = 8'hxx;
    start = 1; tick(1); start = 0;
    for (int c = 1; c <= EXP_DONE + 8; c++) begin
      if (busy) busy_n++;
      if (done) begin done_n++; if (done_cyc == 0) done_cyc = c; end
      if (!mem_rw && mem_addr == 4'd3 && c <= int'(D)) wd3 = mem_wdata;
      start = (c == pulse_at);
      rst   = (c == rst_at);
      tick(1);
    end
    start = 0; rst = 0;
  endtask

  int dc, dn, bn, last_dc;
  logic [7:0] w3;
  initial begin
    tick(2);
    chk("rst_mem_rw", mem_rw, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    rst = 0;
    tick(1);

    run(0, 0, dc, dn, bn, w3);
    chk("clean_done_cycle", dc, EXP_DONE);
    chk("clean_done_count", dn, 1);
    chk("clean_busy_cycles", bn, EXP_DONE - 1);
    chk("clean_wdata_a3", w3, 8'hA6);
    chk("clean_pass", pass, 1);
    chk("clean_fail_cnt", fail_cnt, 0);

    fault_en = 1;
    run(0, 0, dc, dn, bn, w3);
    chk("fault_pass", pass, 0);
    chk("fault_addr", fail_addr, 5);
    chk("fault_cnt", fail_cnt, NP);
    fault_en = 0;

    invalid_all = 1;
    run(0, 0, dc, dn, bn, w3);
    chk("invalid_pass", pass, 0);
    chk("invalid_addr", fail_addr, 0);
    chk("invalid_cnt", fail_cnt, 16 * NP);
    invalid_all = 0;

    run(10, 0, dc, dn, bn, w3);
    chk("ignore_start_done_cycle", dc, EXP_DONE);
    chk("ignore_start_done_count", dn, 1);
    chk("ignore_start_busy", bn, EXP_DONE - 1);
    chk("ignore_start_pass", pass, 1);

    run(0, 20, dc, dn, bn, w3);
    chk("abort_done_count", dn, 0);
    chk("abort_busy_cycles", bn, 20);
    chk("abort_pass", pass, 0);
    run(0, 0, dc, dn, bn, w3);
    chk("after_abort_pass", pass, 1);
    chk("after_abort_done_cycle", dc, EXP_DONE);

    // start held high: back-to-back runs separated by one idle cycle
    dn = 0; last_dc = 0;
    start = 1; tick(1);
    for (int c = 1; c <= 2 * EXP_DONE + 1; c++) begin
      if (done) begin dn++; last_dc = c; end
      tick(1);
    end
    start = 0;
    chk("held_done_count", dn, 2);
    chk("held_second_done", last_dc, 2 * EXP_DONE + 1);
    tick(EXP_DONE + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
